// File: rtl/mul32_seq_ctrl_pkg.sv
// Shared definitions for the sequential 32x32 multiplier controller:
// FSM state encoding, quarter-product shift constants and step helpers.
package mul_seq_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } stateT;

    // Default core operand width; the module parameter may override it.
    localparam int DEF_HALF_W = 16;

    // Quarter-product alignment for the default width.
    localparam int SHIFT_LL  = 0;
    localparam int SHIFT_MID = DEF_HALF_W;
    localparam int SHIFT_HH  = 2 * DEF_HALF_W;

    // Number of core passes per product.
    localparam int NUM_STEPS = 4;

    // Shift applied to the core product at a given step, for a core of
    // width halfW. Order: aL*bL, aH*bL, aL*bH, aH*bH.
    function automatic int stepShift(input logic [1:0] step, input int halfW);
        int sh;
        case (step)
            2'd0:    sh = SHIFT_LL;
            2'd1:    sh = halfW;
            2'd2:    sh = halfW;
            default: sh = 2 * halfW;
        endcase
        return sh;
    endfunction

    // Step bit 0 selects the high half of A, step bit 1 the high half of B.
    function automatic logic stepUsesAHigh(input logic [1:0] step);
        return step[0];
    endfunction

    function automatic logic stepUsesBHigh(input logic [1:0] step);
        return step[1];
    endfunction

endpackage

// File: rtl/mul32_seq_ctrl_if.sv
// Request/response bus of the sequential multiplier controller.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. The source holds valid and its payload steady
// until that edge; ready may be high or low independent of valid.
interface mul32_seq_ctrl_if #(
    parameter int HALF_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*HALF_W-1:0]   in_a;
    logic [2*HALF_W-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*HALF_W-1:0]   out_y;

    // Requester / result consumer side.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y
    );

    // Controller side.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/mul32_seq_ctrl.sv
// Sequencing controller: builds a 4*HALF_W-bit product from four passes
// through one shared, external, combinational HALF_W x HALF_W core.
module mul32_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int HALF_W    = 16,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    mul32_seq_ctrl_if.slave     bus,
    output logic [HALF_W-1:0]   core_a,
    output logic [HALF_W-1:0]   core_b,
    input  logic [2*HALF_W-1:0] core_p,
    output logic                busy,
    output stateT               stateDbg
);

    localparam int FULL_W = 2 * HALF_W;
    localparam int PROD_W = 4 * HALF_W;
    localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

    stateT               state;
    logic [1:0]          step;
    logic [FULL_W-1:0]   opA;
    logic [FULL_W-1:0]   opB;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   accNext;
    logic [PROD_W-1:0]   addend;
    logic [PROD_W-1:0]   outY;
    logic                outValid;
    logic                inReady;
    logic                busyR;
    logic                acceptHit;
    logic                zeroOperand;

    assign acceptHit   = bus.in_valid && inReady;
    assign zeroOperand = (bus.in_a == '0) || (bus.in_b == '0);

    // Operand mux and shifted accumulation; core inputs stay at zero
    // outside MUL so the shared core does not toggle while unused.
    always_comb begin
        core_a = '0;
        core_b = '0;
        if (state == MUL) begin
            core_a = stepUsesAHigh(step) ? opA[FULL_W-1:HALF_W] : opA[HALF_W-1:0];
            core_b = stepUsesBHigh(step) ? opB[FULL_W-1:HALF_W] : opB[HALF_W-1:0];
        end
        addend  = PROD_W'(core_p) << stepShift(step, HALF_W);
        accNext = acc + addend;
    end

    // Controller FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            opA      <= '0;
            opB      <= '0;
            acc      <= '0;
            outY     <= '0;
            outValid <= 1'b0;
            inReady  <= 1'b1;
            busyR    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acceptHit) begin
                        opA     <= bus.in_a;
                        opB     <= bus.in_b;
                        acc     <= '0;
                        step    <= '0;
                        inReady <= 1'b0;
                        busyR   <= 1'b1;
                        if (ZERO_SKIP && zeroOperand) begin
                            // Product is known to be zero; skip the core.
                            outY     <= '0;
                            outValid <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end

                MUL: begin
                    acc  <= accNext;
                    step <= step + 2'd1;
                    if (step == LAST_STEP) begin
                        outY     <= accNext;
                        outValid <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    // Hold the result until it is taken; the next request
                    // is only accepted from the following IDLE cycle.
                    if (bus.out_ready) begin
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        busyR    <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                    inReady  <= 1'b1;
                    busyR    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_y     = outY;
    assign busy          = busyR;
    assign stateDbg      = state;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl with an exact or approximate core model.
module tb_mul32_seq_ctrl;
    import mul_seq_pkg::*;

    localparam int HALF_W = 16;

    logic        clk;
    logic        rst;
    logic [15:0] coreA;
    logic [15:0] coreB;
    logic [31:0] coreP;
    logic        busy;
    stateT       stateDbg;
    logic        useApprox;

    int testsRun    = 0;
    int testsFailed = 0;
    int coreIdleBad = 0;

    logic [31:0] coreLog[$];
    logic [63:0] expQ[$];

    mul32_seq_ctrl_if #(.HALF_W(HALF_W)) bus ();

    mul32_seq_ctrl #(.HALF_W(HALF_W), .ZERO_SKIP(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_a   (coreA),
        .core_b   (coreB),
        .core_p   (coreP),
        .busy     (busy),
        .stateDbg (stateDbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Approximate core: exact product with the five LSBs replaced by the
    // AND of the operands' five LSBs (zero whenever an operand is zero).
    function automatic logic [31:0] approxCore(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p      = 32'(a) * 32'(b);
        p[4:0] = a[4:0] & b[4:0];
        return p;
    endfunction

    function automatic logic [31:0] coreFn(input logic [15:0] a, input logic [15:0] b,
                                           input logic approx);
        return approx ? approxCore(a, b) : 32'(a) * 32'(b);
    endfunction

    // Four-instance combinational 32x32 reference built from the same core.
    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic approx);
        logic [63:0] y;
        y = 64'(coreFn(a[15:0], b[15:0], approx))
          + (64'(coreFn(a[31:16], b[15:0], approx)) << 16)
          + (64'(coreFn(a[15:0], b[31:16], approx)) << 16)
          + (64'(coreFn(a[31:16], b[31:16], approx)) << 32);
        return y;
    endfunction

    always_comb coreP = coreFn(coreA, coreB, useApprox);

    // Record core operands during MUL; flag any toggling outside it.
    always @(negedge clk) begin
        if (!rst) begin
            if (stateDbg == MUL) coreLog.push_back({coreA, coreB});
            else if (coreA != 16'd0 || coreB != 16'd0) coreIdleBad++;
        end
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        checkEq("valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    // Driver: full transaction with out_ready high. lat counts edges from
    // the accept edge (inclusive) to out_valid; busyN counts busy samples.
    task automatic doTxn(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] y, output int lat, output int busyN);
        int waited;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 30) begin
            tick();
            waited++;
        end
        checkEq("accept_timeout", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 32'hDEAD_BEEF;
        bus.in_b     = 32'hCAFE_F00D;
        lat   = 1;
        busyN = busy ? 1 : 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
            if (busy) busyN++;
        end
        checkEq("valid_timeout", 64'(bus.out_valid), 64'd1);
        y = bus.out_y;
        tick();
        if (busy) busyN++;
    endtask

    logic [31:0] vecA[6] = '{32'h0001_0002, 32'h0000_FFFF, 32'h0001_0000,
                             32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] vecB[6] = '{32'h0003_0004, 32'h0000_FFFF, 32'h0001_0000,
                             32'h0000_0002, 32'h0000_0000, 32'h1234_5678};
    logic [63:0] vecY[6] = '{64'h0000_0003_000A_0008, 64'h0000_0000_FFFE_0001,
                             64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
                             64'h0, 64'h0};
    int          vecLat[6] = '{5, 5, 5, 5, 1, 1};

    initial begin
        logic [63:0] y;
        logic [63:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] expCore[4];
        int lat;
        int busyN;
        int n;

        rst           = 1'b1;
        useApprox     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        checkEq("rst_state", 64'(stateDbg), 64'(IDLE));
        checkEq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkEq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkEq("rst_busy", 64'(busy), 64'd0);
        checkEq("rst_out_y", bus.out_y, 64'd0);

        // Scenario 1 with core operand order
        expCore = '{{16'd2, 16'd4}, {16'd1, 16'd4}, {16'd2, 16'd3}, {16'd1, 16'd3}};
        coreLog.delete();
        doTxn(32'h0001_0002, 32'h0003_0004, y, lat, busyN);
        checkEq("s1_y", y, 64'h0000_0003_000A_0008);
        checkEq("s1_lat", 64'(lat), 64'd5);
        checkEq("s1_core_n", 64'(coreLog.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            e = (i < coreLog.size()) ? 64'(coreLog[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
            checkEq($sformatf("s1_core%0d", i), e, 64'(expCore[i]));
        end

        // Scenario 2: all-ones squared, busy window
        doTxn(32'hFFFF_FFFF, 32'hFFFF_FFFF, y, lat, busyN);
        checkEq("s2_y", y, 64'hFFFF_FFFE_0000_0001);
        checkEq("s2_busy", 64'(busyN), 64'd5);

        // Scenario 3: zero skip leaves core untouched
        coreLog.delete();
        doTxn(32'h0000_0000, 32'h1234_5678, y, lat, busyN);
        checkEq("s3_y", y, 64'd0);
        checkEq("s3_lat", 64'(lat), 64'd1);
        checkEq("s3_core_n", 64'(coreLog.size()), 64'd0);
        checkEq("s3_busy", 64'(busyN), 64'd1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            doTxn(vecA[i], vecB[i], y, lat, busyN);
            checkEq($sformatf("vec%0d_y", i), y, vecY[i]);
            checkEq($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecLat[i]));
        end

        // Scenario 4: stall in DONE with a pending request
        bus.out_ready = 1'b0;
        bus.in_a      = 32'h0000_0010;
        bus.in_b      = 32'h0000_0020;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        waitValid(n);
        bus.in_a     = 32'd7;
        bus.in_b     = 32'd6;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkEq("s4_hold_y", bus.out_y, 64'h200);
            checkEq("s4_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        checkEq("s4_still_done", 64'(stateDbg), 64'(DONE));
        bus.out_ready = 1'b1;
        tick();
        checkEq("s4_idle", 64'(stateDbg), 64'(IDLE));
        checkEq("s4_ready_after", 64'(bus.in_ready), 64'd1);
        checkEq("s4_valid_drop", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        checkEq("s4_accepted", 64'(stateDbg), 64'(MUL));
        waitValid(n);
        checkEq("s4_y", bus.out_y, 64'd42);
        tick();

        // Scenario 5: reset during MUL step 2
        bus.in_a     = 32'h1234_5678;
        bus.in_b     = 32'h9ABC_DEF0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        checkEq("s5_mid_mul", 64'(stateDbg), 64'(MUL));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkEq("s5_state", 64'(stateDbg), 64'(IDLE));
        checkEq("s5_out_valid", 64'(bus.out_valid), 64'd0);
        checkEq("s5_in_ready", 64'(bus.in_ready), 64'd1);
        checkEq("s5_busy", 64'(busy), 64'd0);
        checkEq("s5_out_y", bus.out_y, 64'd0);
        doTxn(32'd3, 32'd5, y, lat, busyN);
        checkEq("s5_y", y, 64'd15);

        // Scenario 6: approximate core, random operands via scoreboard
        useApprox = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i % 97 == 5) ra[15:0] = 16'h0;
            if (i % 89 == 7) rb[31:16] = 16'h0;
            expQ.push_back(model32(ra, rb, 1'b1));
            doTxn(ra, rb, y, lat, busyN);
            e = expQ.pop_front();
            checkEq("s6_approx", y, e);
        end

        checkEq("core_idle_quiet", 64'(coreIdleBad), 64'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mul32_seq_ctrl.md
Name: mul32_seq_ctrl

Overview:
Sequencing controller that computes a 32x32 product by time-multiplexing one shared 16x16 recursive approximate multiplier core over four cycles. The core itself is combinational and sits outside this block. The controller owns operand capture, quarter-product scheduling (aL*bL, aH*bL, aL*bH, aH*bH), shifted accumulation and the valid/ready handshakes. It replaces the four-instance 32x32 tree where area matters more than throughput.

Parameters:
HALF_W, 16, width of core operands; full operand width is 2*HALF_W, product width is 4*HALF_W.
ZERO_SKIP, 1, when 1 a zero operand bypasses the core and yields a zero product in one cycle.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  request: operands valid.
in_ready  out  1  controller can accept operands.
in_a  in  2*HALF_W  multiplicand.
in_b  in  2*HALF_W  multiplier.
core_a  out  HALF_W  operand A to shared core.
core_b  out  HALF_W  operand B to shared core.
core_p  in  2*HALF_W  combinational core product of core_a*core_b.
busy  out  1  high in any state other than IDLE.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_y  out  4*HALF_W  product.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE; step counter, accumulator, operand registers and out_y are set to 0.
  - out_valid=0, busy=0, in_ready=1 in the cycle after reset.
  - Reset overrides all other activity, including mid-MUL and a pending DONE; any in-flight result is discarded.
- States: IDLE, MUL, DONE (enum in package).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a/in_b, clear the accumulator, step=0, go to MUL.
  - If ZERO_SKIP=1 and either operand is 0: go directly to DONE with acc=0. The core is not used.
- MUL, step 0..3, one step per cycle:
  - core_a/core_b are selected combinationally from the latched operands:
    - step 0: aL,bL, shift 0.
    - step 1: aH,bL, shift HALF_W.
    - step 2: aL,bH, shift HALF_W.
    - step 3: aH,bH, shift 2*HALF_W.
  - At each edge: acc <= acc + (zero-extended core_p << shift), computed modulo 2^(4*HALF_W). No overflow is possible for an exact core; for the approximate core, wrap is accepted.
  - When step==3, go to DONE and register out_y <= final acc.
  - in_ready=0 throughout MUL.
- DONE:
  - out_valid=1; out_y is held stable until the handshake.
  - On out_valid&out_ready: go to IDLE.
  - in_ready=0 in DONE. There is no back-to-back accept in the same cycle as result handoff; the next request is accepted earliest in the following IDLE cycle.
- Latency: out_valid rises 5 edges after the accept edge (4 MUL steps + DONE register), or 1 edge with zero-skip. Throughput is one result per 6 cycles at best.
- core_a/core_b are driven to 0 outside MUL, so the core toggles no inputs while idle (power).
- If out_ready is held low in DONE, the block stalls indefinitely; no new request is taken.
- in_a/in_b changes while not accepted are ignored. Operands are sampled only on the accept edge.
- The result equals the combinational four-instance recursive product built from the same core, bit for bit.

Decomposition:
- Shared package mul_seq_pkg:
  - state enum {IDLE, MUL, DONE};
  - step-to-shift constants SHIFT_LL=0, SHIFT_MID=HALF_W, SHIFT_HH=2*HALF_W;
  - NUM_STEPS=4.
- No sub-module is needed. The operand mux, accumulator and FSM stay in one module. The 16x16 core is instantiated by the parent, so exact and approximate cores are interchangeable.

Test Plan:
- The bench attaches an exact behavioural 16x16 core unless stated otherwise.
- Directed scenarios:
  1. a=0x0001_0002, b=0x0003_0004 -> out_y=0x0000_0003_000A_0008 after 5 edges. The core sees (2,4),(1,4),(2,3),(1,3) in order.
  2. a=b=0xFFFF_FFFF -> out_y=0xFFFF_FFFE_0000_0001. busy is high for exactly 5 cycles.
  3. a=0, b=0x1234_5678 with ZERO_SKIP=1 -> out_valid after 1 edge, out_y=0, core_a/core_b stay 0.
  4. out_ready held low 10 cycles in DONE -> out_y stable and in_ready=0 throughout. A new in_valid is accepted only the cycle after the handshake.
  5. rst asserted at MUL step 2 -> next cycle IDLE, out_valid=0, acc=0. The next request (a=3,b=5) returns 15.
  6. With the approximate n16_5-style core attached: 1000 random operand pairs -> out_y matches the 32x32 combinational approximate-multiplier model bit-exactly.
